// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-back, write-allocate data cache
// with round-robin replacement and a variable-latency memory handshake.
// One word per line. A miss raises stall until the line is resident again.
module assoc_cache #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wenable,
    input  logic              renable,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              hit,
    output logic              mem_wenable,
    output logic              mem_renable,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic               from_ptr_q, from_ptr_d;

    logic               valid_q [SETS][WAYS];
    logic               valid_d [SETS][WAYS];
    logic               dirty_q [SETS][WAYS];
    logic               dirty_d [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]   tag_d   [SETS][WAYS];
    logic [DATA_W-1:0]  data_q  [SETS][WAYS];
    logic [DATA_W-1:0]  data_d  [SETS][WAYS];
    logic [WAY_W-1:0]   ptr_q   [SETS];
    logic [WAY_W-1:0]   ptr_d   [SETS];

    logic [IDX_W-1:0]   idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic               req_s;
    logic               lookup_hit_s;
    logic [WAY_W-1:0]   hit_way_s;
    logic               any_invalid_s;
    logic [WAY_W-1:0]   inv_way_s;
    logic [WAY_W-1:0]   victim_s;

    logic [DATA_W-1:0]  rdata_s;
    logic               stall_s;
    logic               hit_s;
    logic               mem_we_s;
    logic               mem_re_s;
    logic [DATA_W-1:0]  mem_wdata_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic               unused_s;

    assign idx_s    = addr[2 +: IDX_W];
    assign tag_s    = addr[ADDR_W-1 -: TAG_W];
    assign req_s    = wenable | renable;
    assign unused_s = ^addr[1:0];

    // Tag compare across the indexed set and pick the lowest invalid way as fallback victim.
    always_comb begin
        lookup_hit_s  = 1'b0;
        hit_way_s     = '0;
        any_invalid_s = 1'b0;
        inv_way_s     = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_way_s     = (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s)) ? WAY_W'(w) : hit_way_s;
            lookup_hit_s  = lookup_hit_s | (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s));
            inv_way_s     = (!valid_q[idx_s][w] && !any_invalid_s) ? WAY_W'(w) : inv_way_s;
            any_invalid_s = any_invalid_s | !valid_q[idx_s][w];
        end
        victim_s = any_invalid_s ? inv_way_s : ptr_q[idx_s];
    end

    // Next-state, line update and output decode for the miss-handling FSM.
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        from_ptr_d  = from_ptr_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        ptr_d       = ptr_q;
        rdata_s     = '0;
        stall_s     = 1'b0;
        hit_s       = 1'b0;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_wdata_s = '0;
        mem_addr_s  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_s && lookup_hit_s) begin
                    hit_s = 1'b1;
                    if (wenable) begin
                        data_d[idx_s][hit_way_s]  = wdata;
                        dirty_d[idx_s][hit_way_s] = 1'b1;
                    end else begin
                        rdata_s = data_q[idx_s][hit_way_s];
                    end
                end else if (req_s) begin
                    // Miss: latch the victim now; dirty victims go out before the refill.
                    stall_s    = 1'b1;
                    victim_d   = victim_s;
                    from_ptr_d = !any_invalid_s;
                    if (valid_q[idx_s][victim_s] && dirty_q[idx_s][victim_s]) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                stall_s     = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = {tag_q[idx_s][victim_q], idx_s, 2'b00};
                mem_wdata_s = data_q[idx_s][victim_q];
                if (mem_ready) begin
                    state_d = ST_REFILL;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_REFILL: begin
                stall_s    = 1'b1;
                mem_re_s   = 1'b1;
                mem_addr_s = {addr[ADDR_W-1:2], 2'b00};
                if (mem_ready) begin
                    // A store-miss installs the store data directly and leaves the line dirty.
                    valid_d[idx_s][victim_q] = 1'b1;
                    tag_d[idx_s][victim_q]   = tag_s;
                    data_d[idx_s][victim_q]  = wenable ? wdata : mem_rdata;
                    dirty_d[idx_s][victim_q] = wenable;
                    if (from_ptr_q && (WAYS > 1)) begin
                        ptr_d[idx_s] = ptr_q[idx_s] + WAY_W'(1);
                    end else begin
                        ptr_d[idx_s] = ptr_q[idx_s];
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, victim bookkeeping, valid/dirty bits and round-robin pointers; cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            victim_q   <= '0;
            from_ptr_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            from_ptr_q <= from_ptr_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // Outputs are forced low while reset is asserted so an abandoned miss releases memory at once.
    assign rdata       = {DATA_W{rst}} & rdata_s;
    assign stall       = rst & stall_s;
    assign hit         = rst & hit_s;
    assign mem_wenable = rst & mem_we_s;
    assign mem_renable = rst & mem_re_s;
    assign mem_wdata   = {DATA_W{rst}} & mem_wdata_s;
    assign mem_addr    = {ADDR_W{rst}} & mem_addr_s;

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (SETS=16, WAYS=2) with a backing-memory model
// and a load-data scoreboard.
module tb_assoc_cache;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        wenable = 1'b0;
    logic        renable = 1'b0;
    logic [31:0] rdata;
    logic        stall;
    logic        hit;
    logic        mem_wenable;
    logic        mem_renable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] exp_q [$];

    assoc_cache #(.ADDR_W(32), .DATA_W(32), .SETS(16), .WAYS(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .wenable(wenable), .renable(renable), .rdata(rdata),
        .stall(stall), .hit(hit), .mem_wenable(mem_wenable),
        .mem_renable(mem_renable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : init_val(a);
    endfunction

    task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tg, obs, exp);
        end
    endtask

    // One CPU access serviced to completion; memory answers after 'delay' wait cycles.
    task automatic access(input bit st, input logic [31:0] a, input logic [31:0] wd,
                          input int delay, input int exp_stalls,
                          input logic [31:0] exp_wb, input string tg);
        int stalls = 0;
        int waited = 0;
        bit done = 1'b0;
        bit wb_seen = 1'b0;
        logic [31:0] exp_rd;
        wenable = st;
        renable = !st;
        addr    = a;
        wdata   = wd;
        if (!st) exp_q.push_back(ref_rd(a));
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            if (!stall) begin
                check({tg, "_hit"}, {31'd0, hit}, 32'd1);
                check({tg, "_memidle"}, {30'd0, mem_wenable, mem_renable}, 32'd0);
                if (!st) begin
                    exp_rd = exp_q.pop_front();
                    check({tg, "_rdata"}, rdata, exp_rd);
                end
                done = 1'b1;
            end else begin
                stalls++;
                check({tg, "_hit_in_stall"}, {31'd0, hit}, 32'd0);
                check({tg, "_excl"}, {31'd0, mem_wenable & mem_renable}, 32'd0);
                if (mem_wenable) begin
                    wb_seen = 1'b1;
                    check({tg, "_wb_addr"}, mem_addr, exp_wb);
                    check({tg, "_wb_data"}, mem_wdata, ref_rd(mem_addr));
                    mem_model[mem_addr] = mem_wdata;
                    mem_ready = 1'b1;
                end else if (mem_renable) begin
                    check({tg, "_rf_addr"}, mem_addr, {a[31:2], 2'b00});
                    if (waited < delay) begin
                        waited++;
                        mem_ready = 1'b0;
                    end else begin
                        mem_rdata = mem_rd(mem_addr);
                        mem_ready = 1'b1;
                    end
                end else begin
                    mem_ready = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
        end
        if (!done) begin
            check({tg, "_timeout"}, 32'd1, 32'd0);
            if (!st) void'(exp_q.pop_front());
        end
        check({tg, "_stalls"}, stalls, exp_stalls);
        check({tg, "_wb_seen"}, {31'd0, wb_seen}, {31'd0, exp_wb !== NONE});
        if (st) ref_mem[a] = wd;
        wenable = 1'b0;
        renable = 1'b0;
    endtask

    task automatic check_all_zero(input string tg);
        check({tg, "_rdata"}, rdata, 32'd0);
        check({tg, "_stall"}, {31'd0, stall}, 32'd0);
        check({tg, "_hit"}, {31'd0, hit}, 32'd0);
        check({tg, "_mwe"}, {31'd0, mem_wenable}, 32'd0);
        check({tg, "_mre"}, {31'd0, mem_renable}, 32'd0);
        check({tg, "_mwdata"}, mem_wdata, 32'd0);
        check({tg, "_maddr"}, mem_addr, 32'd0);
    endtask

    initial begin
        mem_model[32'h40] = 32'hDEAD_BEEF;
        ref_mem[32'h40]   = 32'hDEAD_BEEF;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: cold read miss, then hit with refilled data
        access(1'b0, 32'h40, 32'd0, 0, 2, NONE, "t1_cold");
        // 2: write hit, then read back
        access(1'b1, 32'h40, 32'h1234_5678, 0, 0, NONE, "t2_whit");
        access(1'b0, 32'h40, 32'd0, 0, 0, NONE, "t2_rd");
        // 3: fill second way clean, dirty eviction of 0x40 by 0xC0
        access(1'b0, 32'h80, 32'd0, 0, 2, NONE, "t3_fill80");
        access(1'b0, 32'hC0, 32'd0, 0, 3, 32'h40, "t3_evict");
        access(1'b0, 32'h80, 32'd0, 0, 0, NONE, "t3_80hit");
        access(1'b0, 32'h40, 32'd0, 0, 2, NONE, "t3_40miss");
        // 4: slow memory on a clean miss
        access(1'b0, 32'h44, 32'd0, 3, 5, NONE, "t4_slow");

        // 5: reset in the middle of a refill
        renable = 1'b1;
        addr    = 32'h48;
        @(negedge clk);
        check("t5_miss_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_refill_re", {31'd0, mem_renable}, 32'd1);
        check("t5_refill_addr", mem_addr, 32'h48);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("t5_rst");
        renable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ref_mem.delete();
        foreach (mem_model[k]) ref_mem[k] = mem_model[k];
        @(posedge clk);
        #1;
        access(1'b0, 32'h48, 32'd0, 0, 2, NONE, "t5_reread");

        // 6: write-miss allocate, then forced eviction of the dirty line
        access(1'b1, 32'h100, 32'h0000_AAAA, 0, 2, NONE, "t6_wmiss");
        access(1'b0, 32'h100, 32'd0, 0, 0, NONE, "t6_rd");
        access(1'b0, 32'h140, 32'd0, 0, 2, NONE, "t6_fill140");
        access(1'b0, 32'h180, 32'd0, 0, 3, 32'h100, "t6_evict");

        check("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
